// File: rtl/inertial_integrator_cal_pkg.sv
// inertial_pkg: shared types and helpers for the pitch integrator.
//   state_t    - controller state (IDLE / CAL / RUN)
//   acc_width  - accumulator width derived from rate width and fraction bits
//   sat_add    - signed add clamped to a given two's-complement width
package inertial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,   // uncalibrated, integrating with the default offset
    CAL  = 2'd1,   // averaging raw rate samples; accumulator frozen
    RUN  = 2'd2    // calibrated, integrating
  } state_t;

  function automatic int acc_width(input int rate_w, input int frac_w);
    return rate_w + frac_w;
  endfunction

  typedef struct packed {
    logic [63:0] val;  // clamped sum, sign-extended to 64 bits
    logic        sat;  // clamp occurred
  } sat_res_t;

  // Operands are wide enough that a+b never wraps for width <= 62.
  function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                       input logic signed [63:0] b,
                                       input int width);
    sat_res_t r;
    logic signed [63:0] s, hi, lo;
    s  = a + b;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    r.val = s;
    r.sat = 1'b0;
    if (s > hi) begin
      r.val = hi;
      r.sat = 1'b1;
    end else if (s < lo) begin
      r.val = lo;
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/inertial_integrator_cal_if.sv
// Sample / control / status bundle between the inertial front end and the
// pitch integrator.
//   master: drives vld, ptch_rt, AZ, cal_start, fuse_en; observes status
//   slave : the integrator; drives ptch, ptch_rt_off, cal_busy, cal_done, sat
interface inertial_integrator_cal_if #(parameter int RATE_W = 16);
  logic                     vld;
  logic signed [RATE_W-1:0] ptch_rt;
  logic signed [RATE_W-1:0] AZ;
  logic                     cal_start;
  logic                     fuse_en;
  logic signed [RATE_W-1:0] ptch;
  logic signed [RATE_W-1:0] ptch_rt_off;
  logic                     cal_busy;
  logic                     cal_done;
  logic                     sat;

  modport master (
    output vld, ptch_rt, AZ, cal_start, fuse_en,
    input  ptch, ptch_rt_off, cal_busy, cal_done, sat
  );

  modport slave (
    input  vld, ptch_rt, AZ, cal_start, fuse_en,
    output ptch, ptch_rt_off, cal_busy, cal_done, sat
  );
endinterface

// File: rtl/inertial_integrator_cal_rate_offset_cal.sv
// rate_offset_cal: averages 2^CAL_LOG2 raw rate samples into the rate offset.
//   clk, rst_n   - clock, async active-low reset
//   vld, ptch_rt - sample strobe and raw signed rate
//   cal_start    - clears the running sum/count (sample in same cycle dropped)
//   cal_active   - controller is in CAL; samples are only taken then
//   ptch_rt_off  - offset in use (RT_OFF_DFLT until first completion)
//   cal_fin      - combinational: this sample completes the average
//   cal_done     - registered one-cycle completion pulse
module rate_offset_cal #(
  parameter int RATE_W      = 16,
  parameter int CAL_LOG2    = 8,
  parameter int RT_OFF_DFLT = 'h0050
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     vld,
  input  logic signed [RATE_W-1:0] ptch_rt,
  input  logic                     cal_start,
  input  logic                     cal_active,
  output logic signed [RATE_W-1:0] ptch_rt_off,
  output logic                     cal_fin,
  output logic                     cal_done
);
  localparam int SUM_W = RATE_W + CAL_LOG2;

  logic signed [SUM_W-1:0] cal_sum, sum_next;
  logic [CAL_LOG2-1:0]     cal_cnt;
  logic signed [RATE_W-1:0] off_next;

  assign sum_next = cal_sum + SUM_W'(ptch_rt);
  // Arithmetic shift floors toward -inf, e.g. -3.5 -> -4.
  assign off_next = RATE_W'(sum_next >>> CAL_LOG2);
  // Count wraps to zero on the last sample, so all-ones marks the final one.
  assign cal_fin  = cal_active && vld && !cal_start && (&cal_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cal_sum     <= '0;
      cal_cnt     <= '0;
      ptch_rt_off <= RATE_W'(RT_OFF_DFLT);
      cal_done    <= 1'b0;
    end else begin
      cal_done <= cal_fin;
      if (cal_start) begin
        cal_sum <= '0;
        cal_cnt <= '0;
      end else if (cal_active && vld) begin
        if (cal_fin) begin
          ptch_rt_off <= off_next;
          cal_sum     <= '0;
          cal_cnt     <= '0;
        end else begin
          cal_sum <= sum_next;
          cal_cnt <= cal_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/inertial_integrator_cal.sv
// inertial_integrator_cal: offset-compensated pitch-rate integrator with
// complementary correction toward the accelerometer pitch, runtime offset
// calibration and a saturating accumulator.
//   clk, rst_n - clock, async active-low reset
//   bus        - slave side of the sample/control/status bundle
module inertial_integrator_cal
  import inertial_pkg::*;
#(
  parameter int RATE_W      = 16,
  parameter int FRAC_W      = 11,
  parameter int FUSE_STEP   = 1024,
  parameter int AZ_GAIN     = 377,
  parameter int AZ_SHIFT    = 13,
  parameter int AZ_OFFSET   = 'h00A0,
  parameter int RT_OFF_DFLT = 'h0050,
  parameter int CAL_LOG2    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  inertial_integrator_cal_if.slave  bus
);
  localparam int ACC_W  = acc_width(RATE_W, FRAC_W);
  localparam int PROD_W = RATE_W + 33;

  state_t state_q, state_d;

  logic signed [ACC_W-1:0]  ptch_int;
  logic signed [RATE_W-1:0] ptch_q, off;
  logic signed [RATE_W:0]   rt_comp, az_comp;
  logic signed [PROD_W-1:0] az_prod;
  logic signed [RATE_W-1:0] ptch_acc;
  logic signed [ACC_W+1:0]  fuse;
  sat_res_t                 sum_res;
  logic                     cal_fin, cal_done, sat_q;

  rate_offset_cal #(
    .RATE_W      (RATE_W),
    .CAL_LOG2    (CAL_LOG2),
    .RT_OFF_DFLT (RT_OFF_DFLT)
  ) u_cal (
    .clk         (clk),
    .rst_n       (rst_n),
    .vld         (bus.vld),
    .ptch_rt     (bus.ptch_rt),
    .cal_start   (bus.cal_start),
    .cal_active  (state_q == CAL),
    .ptch_rt_off (off),
    .cal_fin     (cal_fin),
    .cal_done    (cal_done)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.cal_start)  state_d = CAL;
    else if (cal_fin)   state_d = RUN;
  end

  // ---------------- datapath ----------------
  assign ptch_q  = ptch_int[ACC_W-1:FRAC_W];
  // One extra bit so neither subtraction can wrap.
  assign rt_comp = (RATE_W+1)'(bus.ptch_rt) - (RATE_W+1)'(off);
  assign az_comp = (RATE_W+1)'(bus.AZ) - (RATE_W+1)'(AZ_OFFSET);
  assign az_prod = PROD_W'(az_comp) * PROD_W'(AZ_GAIN);
  assign ptch_acc = RATE_W'(az_prod >>> AZ_SHIFT);

  // Fixed-step nudge toward the accelerometer pitch, compared against the
  // registered (not the about-to-be-updated) pitch.
  always_comb begin
    fuse = '0;
    if (bus.fuse_en) begin
      if (ptch_acc > ptch_q) fuse =  (ACC_W+2)'(FUSE_STEP);
      else                   fuse = -(ACC_W+2)'(FUSE_STEP);
    end
  end

  assign sum_res = sat_add(64'(ptch_int), 64'(fuse) - 64'(rt_comp), ACC_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptch_int <= '0;
      sat_q    <= 1'b0;
    end else if (bus.cal_start) begin
      ptch_int <= '0;
      sat_q    <= 1'b0;
    end else if (bus.vld && state_q != CAL) begin
      ptch_int <= ACC_W'(sum_res.val);
      if (sum_res.sat) sat_q <= 1'b1;
    end
  end

  assign bus.ptch        = ptch_q;
  assign bus.ptch_rt_off = off;
  assign bus.cal_busy    = (state_q == CAL);
  assign bus.cal_done    = cal_done;
  assign bus.sat         = sat_q;
endmodule

// File: tb/tb_inertial_integrator_cal.sv
// Directed bench for inertial_integrator_cal. Inputs change 1 ns after a
// rising edge and outputs are sampled at the same point, i.e. after the
// edge that consumed the previous inputs.
module tb_inertial_integrator_cal;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  inertial_integrator_cal_if #(.RATE_W(16)) bus ();

  inertial_integrator_cal dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic vld_pulse(input logic [15:0] rt, input logic [15:0] az);
    bus.ptch_rt = rt;
    bus.AZ      = az;
    bus.vld     = 1'b1;
    @(posedge clk); #1;
    bus.vld     = 1'b0;
  endtask

  task automatic cal_pulse(input logic with_vld);
    bus.cal_start = 1'b1;
    bus.vld       = with_vld;
    @(posedge clk); #1;
    bus.cal_start = 1'b0;
    bus.vld       = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (bus.ptch !== 16'h0000) begin n_fail++; $display("FAIL reset_ptch got %h want 0000", bus.ptch); end
    n_cmp++; if (bus.ptch_rt_off !== 16'h0050) begin n_fail++; $display("FAIL reset_off got %h want 0050", bus.ptch_rt_off); end
    n_cmp++; if (bus.cal_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.cal_busy); end
    n_cmp++; if (bus.cal_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.cal_done); end
    n_cmp++; if (bus.sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat got %b want 0", bus.sat); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // rt_comp = 0x850-0x50 = 2048 per sample -> ptch_int -2048*n
  task automatic test_integrate();
    bus.fuse_en = 1'b0;
    vld_pulse(16'h0850, 16'h00A0);
    n_cmp++; if (bus.ptch !== 16'hFFFF) begin n_fail++; $display("FAIL int_first got %h want FFFF", bus.ptch); end
    repeat (7) vld_pulse(16'h0850, 16'h00A0);
    n_cmp++; if (bus.ptch !== 16'hFFF8) begin n_fail++; $display("FAIL int_eight got %h want FFF8", bus.ptch); end
    n_cmp++; if (bus.ptch_rt_off !== 16'h0050) begin n_fail++; $display("FAIL int_off got %h want 0050", bus.ptch_rt_off); end
    n_cmp++; if (bus.sat !== 1'b0) begin n_fail++; $display("FAIL int_sat got %b want 0", bus.sat); end
  endtask

  task automatic test_cal();
    int bad;
    cal_pulse(1'b0);
    n_cmp++; if (bus.cal_busy !== 1'b1) begin n_fail++; $display("FAIL cal_busy_start got %b want 1", bus.cal_busy); end
    n_cmp++; if (bus.ptch !== 16'h0000) begin n_fail++; $display("FAIL cal_ptch_clear got %h want 0000", bus.ptch); end
    bad = 0;
    for (int i = 0; i < 255; i++) begin
      vld_pulse(16'h0030, 16'h00A0);
      if (bus.cal_busy !== 1'b1 || bus.cal_done !== 1'b0 || bus.ptch !== 16'h0000) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL cal_during bad_cycles %0d want 0", bad); end
    vld_pulse(16'h0030, 16'h00A0);
    n_cmp++; if (bus.cal_done !== 1'b1) begin n_fail++; $display("FAIL cal_done_pulse got %b want 1", bus.cal_done); end
    n_cmp++; if (bus.cal_busy !== 1'b0) begin n_fail++; $display("FAIL cal_busy_end got %b want 0", bus.cal_busy); end
    n_cmp++; if (bus.ptch_rt_off !== 16'h0030) begin n_fail++; $display("FAIL cal_off got %h want 0030", bus.ptch_rt_off); end
    @(posedge clk); #1;
    n_cmp++; if (bus.cal_done !== 1'b0) begin n_fail++; $display("FAIL cal_done_width got %b want 0", bus.cal_done); end
  endtask

  // -3/-4 alternating: sum -896, /256 = -3.5, floor -4
  task automatic test_cal_floor();
    cal_pulse(1'b0);
    for (int i = 0; i < 256; i++)
      vld_pulse((i % 2 == 0) ? 16'hFFFD : 16'hFFFC, 16'h00A0);
    n_cmp++; if (bus.ptch_rt_off !== 16'hFFFC) begin n_fail++; $display("FAIL floor_off got %h want FFFC", bus.ptch_rt_off); end
    bus.fuse_en = 1'b0;
    vld_pulse(16'hFFFC, 16'h00A0);
    n_cmp++; if (bus.ptch !== 16'h0000) begin n_fail++; $display("FAIL floor_hold got %h want 0000", bus.ptch); end
  endtask

  // Offset -4, rate -4 -> rt_comp 0. AZ 0x00A0 -> acc 0; 0x20A0 -> +377;
  // 0xE0A0 -> -377. ptch is the floor of ptch_int/2048.
  task automatic test_fusion();
    bus.fuse_en = 1'b1;
    vld_pulse(16'hFFFC, 16'h00A0);   // 0>0 false: -1024
    n_cmp++; if (bus.ptch !== 16'hFFFF) begin n_fail++; $display("FAIL fuse_v1 got %h want FFFF", bus.ptch); end
    vld_pulse(16'hFFFC, 16'h00A0);   // 0>-1 true: 0
    n_cmp++; if (bus.ptch !== 16'h0000) begin n_fail++; $display("FAIL fuse_v2 got %h want 0000", bus.ptch); end
    vld_pulse(16'hFFFC, 16'h00A0);   // 0>0 false: -1024
    n_cmp++; if (bus.ptch !== 16'hFFFF) begin n_fail++; $display("FAIL fuse_v3 got %h want FFFF", bus.ptch); end
    bus.fuse_en = 1'b0;
    vld_pulse(16'hFFFC, 16'h20A0);   // no correction: stays -1024
    n_cmp++; if (bus.ptch !== 16'hFFFF) begin n_fail++; $display("FAIL fuse_off got %h want FFFF", bus.ptch); end
    bus.fuse_en = 1'b1;
    repeat (3) vld_pulse(16'hFFFC, 16'h20A0);  // 0, 1024, 2048
    n_cmp++; if (bus.ptch !== 16'h0001) begin n_fail++; $display("FAIL fuse_pos got %h want 0001", bus.ptch); end
    repeat (3) vld_pulse(16'hFFFC, 16'hE0A0);  // 1024, 0, -1024
    n_cmp++; if (bus.ptch !== 16'hFFFF) begin n_fail++; $display("FAIL fuse_neg got %h want FFFF", bus.ptch); end
    bus.fuse_en = 1'b0;
  endtask

  // 0x8000 - 0x50 = -32848 -> +32848/sample; 2043 samples = 67108464, next clamps.
  // 0x7FFF - 0x50 = 32687 -> 4106 samples to -67103959, next clamps at -2^26.
  task automatic test_saturation();
    apply_reset();
    bus.fuse_en = 1'b0;
    repeat (2043) vld_pulse(16'h8000, 16'h00A0);
    n_cmp++; if (bus.sat !== 1'b0) begin n_fail++; $display("FAIL sat_early got %b want 0", bus.sat); end
    n_cmp++; if (bus.ptch !== 16'h7FFF) begin n_fail++; $display("FAIL sat_pre_ptch got %h want 7FFF", bus.ptch); end
    vld_pulse(16'h8000, 16'h00A0);
    n_cmp++; if (bus.sat !== 1'b1) begin n_fail++; $display("FAIL sat_set got %b want 1", bus.sat); end
    n_cmp++; if (bus.ptch !== 16'h7FFF) begin n_fail++; $display("FAIL sat_max got %h want 7FFF", bus.ptch); end
    repeat (4106) vld_pulse(16'h7FFF, 16'h00A0);
    n_cmp++; if (bus.ptch !== 16'h8002) begin n_fail++; $display("FAIL sat_pre_min got %h want 8002", bus.ptch); end
    n_cmp++; if (bus.sat !== 1'b1) begin n_fail++; $display("FAIL sat_sticky got %b want 1", bus.sat); end
    vld_pulse(16'h7FFF, 16'h00A0);
    n_cmp++; if (bus.ptch !== 16'h8000) begin n_fail++; $display("FAIL sat_min got %h want 8000", bus.ptch); end
    cal_pulse(1'b0);
    n_cmp++; if (bus.sat !== 1'b0) begin n_fail++; $display("FAIL sat_clear got %b want 0", bus.sat); end
    n_cmp++; if (bus.ptch !== 16'h0000) begin n_fail++; $display("FAIL sat_ptch_clear got %h want 0000", bus.ptch); end
  endtask

  task automatic test_back_to_back();
    int bad;
    // Same-cycle vld must be dropped: done on the 256th following sample.
    bus.ptch_rt = 16'h1000;
    cal_pulse(1'b1);
    bad = 0;
    for (int i = 0; i < 255; i++) begin
      vld_pulse(16'h0000, 16'h00A0);
      if (bus.cal_done !== 1'b0 || bus.cal_busy !== 1'b1) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_drop bad_cycles %0d want 0", bad); end
    vld_pulse(16'h0000, 16'h00A0);
    n_cmp++; if (bus.cal_done !== 1'b1) begin n_fail++; $display("FAIL b2b_done got %b want 1", bus.cal_done); end
    n_cmp++; if (bus.ptch_rt_off !== 16'h0000) begin n_fail++; $display("FAIL b2b_off got %h want 0000", bus.ptch_rt_off); end

    // Asynchronous reset at sample 100, checked before any clock edge.
    cal_pulse(1'b0);
    repeat (100) vld_pulse(16'h0020, 16'h00A0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.ptch_rt_off !== 16'h0050) begin n_fail++; $display("FAIL arst_off got %h want 0050", bus.ptch_rt_off); end
    n_cmp++; if (bus.cal_busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy got %b want 0", bus.cal_busy); end
    n_cmp++; if (bus.ptch !== 16'h0000) begin n_fail++; $display("FAIL arst_ptch got %h want 0000", bus.ptch); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Restart mid-calibration: needs a full 256 fresh samples.
    cal_pulse(1'b0);
    repeat (100) vld_pulse(16'h0040, 16'h00A0);
    cal_pulse(1'b0);
    bad = 0;
    for (int i = 0; i < 255; i++) begin
      vld_pulse(16'h0010, 16'h00A0);
      if (bus.cal_done !== 1'b0 || bus.cal_busy !== 1'b1) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL restart_early bad_cycles %0d want 0", bad); end
    vld_pulse(16'h0010, 16'h00A0);
    n_cmp++; if (bus.cal_done !== 1'b1) begin n_fail++; $display("FAIL restart_done got %b want 1", bus.cal_done); end
    n_cmp++; if (bus.ptch_rt_off !== 16'h0010) begin n_fail++; $display("FAIL restart_off got %h want 0010", bus.ptch_rt_off); end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.vld       = 1'b0;
    bus.ptch_rt   = '0;
    bus.AZ        = 16'h00A0;
    bus.cal_start = 1'b0;
    bus.fuse_en   = 1'b0;
    test_reset();
    test_integrate();
    test_cal();
    test_cal_floor();
    test_fusion();
    test_saturation();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
